udt_ctrl_demux: RTL and testbench

Packet classifier that sits directly upstream of the CLOSE handler. It takes the receive-side 64-bit AXI-Stream of UDT packets, decodes the header on the first beat, and steers each whole packet to one of three output streams: data, general control, or close/shutdown. The close output feeds the CLOSE handler's close_t* inputs. Malformed packets and unknown control types are dropped and flagged.

---
 rtl/udt_ctrl_demux.sv | 223 ++++++++++++++++++++++
 tb/tb_udt_ctrl_demux.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/udt_ctrl_demux.sv
// udt_ctrl_demux
//   Steers whole UDT packets from one 64-bit receive AXI-Stream to one of
//   three output streams. The header is decoded on the first beat of each
//   packet:
//     data  : bit63 = 0
//     ctrl  : bit63 = 1, type <= MAX_STD_TYPE or type == USER_TYPE
//     close : bit63 = 1, type == CLOSE_TYPE (feeds the CLOSE handler)
//   Unknown control types and malformed heads are dropped and flagged with
//   a one-cycle drop_pulse_o. A malformed head is a last beat with fewer
//   than 8 valid bytes.
//
//   A single holding register sits between the input and all three outputs.
//   tdata/tkeep/tlast are shared by the three ports; only tvalid is steered.
//
// Ports
//   core_clk, core_rst           clock, synchronous active-high reset
//   in_t*                        receive stream (in_tready_o is the backpressure)
//   data_t*  / data_tready_i     data-packet stream
//   ctrl_t*  / ctrl_tready_i     control stream; ctrl_type_o holds the type
//                                of the packet currently on it
//   close_t* / close_tready_i    shutdown stream to the CLOSE handler
//   drop_pulse_o                 one pulse per dropped packet
//
// Optional build macro UDT_CTRL_DEMUX_STATS_EN adds per-destination packet
// counters (pkt_cnt_*_o) and a synchronous clear input stats_clr_i.
module udt_ctrl_demux #(
  parameter logic [14:0] CLOSE_TYPE   = 15'd5,
  parameter logic [14:0] USER_TYPE    = 15'h7FFF,
  parameter logic [14:0] MAX_STD_TYPE = 15'd7
) (
  input  logic        core_clk,
  input  logic        core_rst,
  input  logic        in_tvalid_i,
  input  logic [63:0] in_tdata_i,
  input  logic [7:0]  in_tkeep_i,
  input  logic        in_tlast_i,
  output logic        in_tready_o,
  output logic        data_tvalid_o,
  output logic [63:0] data_tdata_o,
  output logic [7:0]  data_tkeep_o,
  output logic        data_tlast_o,
  input  logic        data_tready_i,
  output logic        ctrl_tvalid_o,
  output logic [63:0] ctrl_tdata_o,
  output logic [7:0]  ctrl_tkeep_o,
  output logic        ctrl_tlast_o,
  input  logic        ctrl_tready_i,
  output logic [14:0] ctrl_type_o,
  output logic        close_tvalid_o,
  output logic [63:0] close_tdata_o,
  output logic [7:0]  close_tkeep_o,
  output logic        close_tlast_o,
  input  logic        close_tready_i,
  output logic        drop_pulse_o
`ifdef UDT_CTRL_DEMUX_STATS_EN
  ,
  input  logic        stats_clr_i,
  output logic [31:0] pkt_cnt_data_o,
  output logic [31:0] pkt_cnt_ctrl_o,
  output logic [31:0] pkt_cnt_close_o,
  output logic [31:0] pkt_cnt_drop_o
`endif
);

  localparam int DATA_W = 64;
  localparam int KEEP_W = 8;
  localparam int TYPE_W = 15;

  typedef enum logic [1:0] {ST_HEAD, ST_FWD, ST_DROP} state_t;
  typedef enum logic [1:0] {DST_DATA, DST_CTRL, DST_CLOSE, DST_NONE} dest_t;

  // Destination of a head beat; DST_NONE means the packet is discarded.
  function automatic dest_t classify(input logic [DATA_W-1:0] hdr,
                                     input logic [KEEP_W-1:0] keep,
                                     input logic              last);
    logic [TYPE_W-1:0] typ;
    dest_t             dst;
    typ = hdr[62:48];
    if (last && (keep != {KEEP_W{1'b1}}))
      dst = DST_NONE;
    else if (!hdr[63])
      dst = DST_DATA;
    else if (typ == CLOSE_TYPE)
      dst = DST_CLOSE;
    else if ((typ <= MAX_STD_TYPE) || (typ == USER_TYPE))
      dst = DST_CTRL;
    else
      dst = DST_NONE;
    return dst;
  endfunction

  state_t              state_q, state_d;
  dest_t               dest_p0, dest_d, head_dest;
  logic                vld_p0;
  logic [DATA_W-1:0]   data_p0;
  logic [KEEP_W-1:0]   keep_p0;
  logic                last_p0;
  logic [TYPE_W-1:0]   ctype_p0;
  logic                drop_p0;
  logic                hold_ready, accept, load, ctype_ld, drop_head;

  assign hold_ready  = ((dest_p0 == DST_DATA)  && data_tready_i) ||
                       ((dest_p0 == DST_CTRL)  && ctrl_tready_i) ||
                       ((dest_p0 == DST_CLOSE) && close_tready_i);
  // In DROP the input never waits on the register: discarded beats bypass it.
  assign in_tready_o = !vld_p0 || hold_ready || (state_q == ST_DROP);
  assign accept      = in_tvalid_i && in_tready_o;
  assign head_dest   = classify(in_tdata_i, in_tkeep_i, in_tlast_i);

  always_comb begin
    state_d   = state_q;
    dest_d    = dest_p0;
    load      = 1'b0;
    ctype_ld  = 1'b0;
    drop_head = 1'b0;
    case (state_q)
      ST_HEAD: begin
        if (accept) begin
          if (head_dest == DST_NONE) begin
            drop_head = 1'b1;
            if (!in_tlast_i) state_d = ST_DROP;
          end else begin
            load     = 1'b1;
            dest_d   = head_dest;
            ctype_ld = (head_dest == DST_CTRL);
            if (!in_tlast_i) state_d = ST_FWD;
          end
        end
      end
      ST_FWD: begin
        if (accept) begin
          load = 1'b1;
          if (in_tlast_i) state_d = ST_HEAD;
        end
      end
      ST_DROP: begin
        if (accept && in_tlast_i) state_d = ST_HEAD;
      end
      default: state_d = ST_HEAD;
    endcase
  end

  // Stage p0: holding register control
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      state_q <= ST_HEAD;
      vld_p0  <= 1'b0;
      dest_p0 <= DST_DATA;
      drop_p0 <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_p0 <= drop_head;
      if (load) begin
        vld_p0  <= 1'b1;
        dest_p0 <= dest_d;
      end else if (hold_ready) begin
        vld_p0  <= 1'b0;
      end
    end
  end

  // Stage p0: holding register payload (outputs are defined as 0 after reset)
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      data_p0  <= '0;
      keep_p0  <= '0;
      last_p0  <= 1'b0;
      ctype_p0 <= '0;
    end else begin
      if (load) begin
        data_p0 <= in_tdata_i;
        keep_p0 <= in_tkeep_i;
        last_p0 <= in_tlast_i;
      end
      if (ctype_ld) ctype_p0 <= in_tdata_i[62:48];
    end
  end

  assign data_tvalid_o  = vld_p0 && (dest_p0 == DST_DATA);
  assign ctrl_tvalid_o  = vld_p0 && (dest_p0 == DST_CTRL);
  assign close_tvalid_o = vld_p0 && (dest_p0 == DST_CLOSE);
  assign data_tdata_o   = data_p0;
  assign ctrl_tdata_o   = data_p0;
  assign close_tdata_o  = data_p0;
  assign data_tkeep_o   = keep_p0;
  assign ctrl_tkeep_o   = keep_p0;
  assign close_tkeep_o  = keep_p0;
  assign data_tlast_o   = last_p0;
  assign ctrl_tlast_o   = last_p0;
  assign close_tlast_o  = last_p0;
  assign ctrl_type_o    = ctype_p0;
  assign drop_pulse_o   = drop_p0;

`ifdef UDT_CTRL_DEMUX_STATS_EN
  logic        head_acc;
  logic [31:0] cnt_data, cnt_ctrl, cnt_close, cnt_drop;

  assign head_acc = (state_q == ST_HEAD) && accept;

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge core_clk) begin
    if (core_rst || stats_clr_i) begin
      cnt_data  <= '0;
      cnt_ctrl  <= '0;
      cnt_close <= '0;
      cnt_drop  <= '0;
    end else if (head_acc) begin
      case (head_dest)
        DST_DATA:  cnt_data  <= cnt_data  + 32'd1;
        DST_CTRL:  cnt_ctrl  <= cnt_ctrl  + 32'd1;
        DST_CLOSE: cnt_close <= cnt_close + 32'd1;
        default:   cnt_drop  <= cnt_drop  + 32'd1;
      endcase
    end
  end

  assign pkt_cnt_data_o  = cnt_data;
  assign pkt_cnt_ctrl_o  = cnt_ctrl;
  assign pkt_cnt_close_o = cnt_close;
  assign pkt_cnt_drop_o  = cnt_drop;
`endif

endmodule

// File: tb/tb_udt_ctrl_demux.sv
// Directed bench for udt_ctrl_demux. A packet-level model classifies each
// packet from its head and queues the beats expected on each port; a
// negedge compare process checks every presented output beat against it.
module tb_udt_ctrl_demux;

  logic        core_clk = 1'b0;
  logic        core_rst;
  logic        in_tvalid_i;
  logic [63:0] in_tdata_i;
  logic [7:0]  in_tkeep_i;
  logic        in_tlast_i;
  logic        in_tready_o;
  logic        data_tvalid_o, ctrl_tvalid_o, close_tvalid_o;
  logic [63:0] data_tdata_o, ctrl_tdata_o, close_tdata_o;
  logic [7:0]  data_tkeep_o, ctrl_tkeep_o, close_tkeep_o;
  logic        data_tlast_o, ctrl_tlast_o, close_tlast_o;
  logic        data_tready_i, ctrl_tready_i, close_tready_i;
  logic [14:0] ctrl_type_o;
  logic        drop_pulse_o;

  udt_ctrl_demux dut (
    .core_clk       (core_clk),
    .core_rst       (core_rst),
    .in_tvalid_i    (in_tvalid_i),
    .in_tdata_i     (in_tdata_i),
    .in_tkeep_i     (in_tkeep_i),
    .in_tlast_i     (in_tlast_i),
    .in_tready_o    (in_tready_o),
    .data_tvalid_o  (data_tvalid_o),
    .data_tdata_o   (data_tdata_o),
    .data_tkeep_o   (data_tkeep_o),
    .data_tlast_o   (data_tlast_o),
    .data_tready_i  (data_tready_i),
    .ctrl_tvalid_o  (ctrl_tvalid_o),
    .ctrl_tdata_o   (ctrl_tdata_o),
    .ctrl_tkeep_o   (ctrl_tkeep_o),
    .ctrl_tlast_o   (ctrl_tlast_o),
    .ctrl_tready_i  (ctrl_tready_i),
    .ctrl_type_o    (ctrl_type_o),
    .close_tvalid_o (close_tvalid_o),
    .close_tdata_o  (close_tdata_o),
    .close_tkeep_o  (close_tkeep_o),
    .close_tlast_o  (close_tlast_o),
    .close_tready_i (close_tready_i),
    .drop_pulse_o   (drop_pulse_o)
  );

  always #5 core_clk = ~core_clk;

  // port codes: 0 data, 1 ctrl, 2 close, 3 dropped
  typedef struct packed {
    logic [1:0]  port;
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [14:0] t;
  } beat_t;

  beat_t       exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          drop_seen = 0;
  int          exp_drops = 0;
  bit          m_in_pkt = 1'b0;
  logic [1:0]  m_cls = 2'd0;
  logic [14:0] m_type = 15'd0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  // Packet classification straight from the header rules.
  function automatic logic [1:0] classify(logic [63:0] d, logic [7:0] k, logic l);
    logic [14:0] t;
    t = d[62:48];
    if (l && k != 8'hFF) return 2'd3;
    if (!d[63]) return 2'd0;
    if (t == 15'd5) return 2'd2;
    if (t <= 15'd7 || t == 15'h7FFF) return 2'd1;
    return 2'd3;
  endfunction

  function automatic void model_accept(logic [63:0] d, logic [7:0] k, logic l);
    if (!m_in_pkt) begin
      m_cls  = classify(d, k, l);
      m_type = d[62:48];
      if (m_cls == 2'd3) exp_drops++;
    end
    if (m_cls != 2'd3) exp_q.push_back('{m_cls, d, k, l, m_type});
    m_in_pkt = !l;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_in_pkt = 1'b0;
  endfunction

  // Present one beat from posedge+1 and return at posedge+1 after it is taken.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k,
                           input logic l, output int waits);
    bit acc;
    waits = 0;
    acc = 1'b0;
    in_tvalid_i = 1'b1;
    in_tdata_i  = d;
    in_tkeep_i  = k;
    in_tlast_i  = l;
    while (!acc) begin
      @(negedge core_clk);
      acc = in_tready_o;
      @(posedge core_clk);
      #1;
      if (!acc) begin
        waits++;
        if (waits > 50) begin
          n_vec++;
          n_err++;
          $display("FAIL accept_timeout: beat %0h not taken, required within 50 cycles", d);
          break;
        end
      end
    end
    in_tvalid_i = 1'b0;
    if (acc) model_accept(d, k, l);
  endtask

  // Compare process: every presented beat against the model queue head.
  always @(negedge core_clk) begin
    int          nv;
    logic [1:0]  port;
    logic        rdy;
    logic [63:0] od;
    logic [7:0]  ok;
    logic        ol;
    beat_t       e;
    nv = int'(data_tvalid_o) + int'(ctrl_tvalid_o) + int'(close_tvalid_o);
    if (nv > 1) chk("valid_onehot", 64'(nv), 64'd1);
    if (nv == 1) begin
      if (data_tvalid_o) begin
        port = 2'd0; rdy = data_tready_i; od = data_tdata_o; ok = data_tkeep_o; ol = data_tlast_o;
      end else if (ctrl_tvalid_o) begin
        port = 2'd1; rdy = ctrl_tready_i; od = ctrl_tdata_o; ok = ctrl_tkeep_o; ol = ctrl_tlast_o;
      end else begin
        port = 2'd2; rdy = close_tready_i; od = close_tdata_o; ok = close_tkeep_o; ol = close_tlast_o;
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_beat_port", 64'(port), 64'd3);
      end else begin
        e = exp_q[0];
        chk("out_port", 64'(port), 64'(e.port));
        chk("out_tdata", od, e.d);
        chk("out_tkeep", 64'(ok), 64'(e.k));
        chk("out_tlast", 64'(ol), 64'(e.l));
        if (port == 2'd1) chk("out_ctrl_type", 64'(ctrl_type_o), 64'(e.t));
        if (rdy) void'(exp_q.pop_front());
      end
    end
    if (drop_pulse_o) drop_seen++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] b[4];
    int w;
    int d0;
    core_rst = 1'b1;
    in_tvalid_i = 1'b0;
    in_tdata_i = '0;
    in_tkeep_i = '0;
    in_tlast_i = 1'b0;
    data_tready_i = 1'b1;
    ctrl_tready_i = 1'b1;
    close_tready_i = 1'b1;
    repeat (3) @(posedge core_clk);
    #1;
    chk("rst_data_vld", 64'(data_tvalid_o), 64'd0);
    chk("rst_ctrl_vld", 64'(ctrl_tvalid_o), 64'd0);
    chk("rst_close_vld", 64'(close_tvalid_o), 64'd0);
    chk("rst_tdata", data_tdata_o, 64'd0);
    chk("rst_ctrl_type", 64'(ctrl_type_o), 64'd0);
    chk("rst_drop", 64'(drop_pulse_o), 64'd0);
    core_rst = 1'b0;
    @(posedge core_clk); #1;
    chk("rst_tready", 64'(in_tready_o), 64'd1);

    // 3-beat close packet
    b[0] = 64'h8005_0000_0000_0001;
    b[1] = 64'h1111_2222_3333_4444;
    b[2] = 64'h5555_6666_7777_8888;
    for (int i = 0; i < 3; i++) begin
      send_beat(b[i], 8'hFF, i == 2, w);
      chk("close_wait", 64'(w), 64'd0);
      chk("close_vld", 64'(close_tvalid_o), 64'd1);
      chk("close_data_vld", 64'(data_tvalid_o), 64'd0);
      chk("close_ctrl_vld", 64'(ctrl_tvalid_o), 64'd0);
      chk("close_tdata", close_tdata_o, b[i]);
      chk("close_tlast", 64'(close_tlast_o), (i == 2) ? 64'd1 : 64'd0);
    end

    // data packet then ACK packet back to back
    b[0] = 64'h0123_4567_89AB_CDEF;
    b[1] = 64'hDEAD_BEEF_0000_0001;
    b[2] = 64'h8002_0000_0000_00AA;
    b[3] = 64'h0000_0000_0000_00BB;
    for (int i = 0; i < 4; i++) begin
      send_beat(b[i], (i == 3) ? 8'h3F : 8'hFF, i == 1 || i == 3, w);
      chk("b2b_wait", 64'(w), 64'd0);
      chk("b2b_data_vld", 64'(data_tvalid_o), (i < 2) ? 64'd1 : 64'd0);
      chk("b2b_ctrl_vld", 64'(ctrl_tvalid_o), (i >= 2) ? 64'd1 : 64'd0);
      if (i >= 2) chk("b2b_ctrl_type", 64'(ctrl_type_o), 64'd2);
    end
    send_beat(64'h0000_0000_0000_0077, 8'hFF, 1'b1, w);
    chk("hold_ctrl_type", 64'(ctrl_type_o), 64'd2);
    chk("hold_data_vld", 64'(data_tvalid_o), 64'd1);

    // close packet stalled downstream for 5 cycles
    b[0] = 64'h8005_0000_0000_0010;
    b[1] = 64'hAAAA_0000_0000_0011;
    b[2] = 64'hBBBB_0000_0000_0012;
    close_tready_i = 1'b0;
    send_beat(b[0], 8'hFF, 1'b0, w);
    fork
      begin
        send_beat(b[1], 8'hFF, 1'b0, w);
        chk("stall_release_wait", 64'(w > 0), 64'd1);
        send_beat(b[2], 8'hFF, 1'b1, w);
      end
      begin
        repeat (5) begin
          @(negedge core_clk);
          chk("stall_tready", 64'(in_tready_o), 64'd0);
          chk("stall_vld", 64'(close_tvalid_o), 64'd1);
          chk("stall_tdata", close_tdata_o, b[0]);
        end
        @(posedge core_clk); #1;
        close_tready_i = 1'b1;
      end
    join
    repeat (3) @(posedge core_clk);
    #1;

    // unknown type 0x0010, 4 beats, then a data packet
    d0 = drop_seen;
    for (int i = 0; i < 4; i++) begin
      send_beat((i == 0) ? 64'h8010_0000_0000_0000 : 64'(i), 8'hFF, i == 3, w);
      chk("drop_wait", 64'(w), 64'd0);
      chk("drop_any_vld", 64'(data_tvalid_o | ctrl_tvalid_o | close_tvalid_o), 64'd0);
      chk("drop_pulse_lvl", 64'(drop_pulse_o), (i == 0) ? 64'd1 : 64'd0);
    end
    send_beat(64'h0000_0000_0000_0099, 8'hFF, 1'b1, w);
    chk("after_drop_data_vld", 64'(data_tvalid_o), 64'd1);
    repeat (2) @(posedge core_clk);
    #1;
    chk("drop_pulse_count", 64'(drop_seen - d0), 64'd1);

    // malformed single-beat head, then a user-type packet
    d0 = drop_seen;
    send_beat(64'h8005_0000_0000_0000, 8'h0F, 1'b1, w);
    chk("malf_pulse", 64'(drop_pulse_o), 64'd1);
    chk("malf_any_vld", 64'(data_tvalid_o | ctrl_tvalid_o | close_tvalid_o), 64'd0);
    send_beat(64'hFFFF_0000_0000_0001, 8'hFF, 1'b0, w);
    chk("user_ctrl_vld", 64'(ctrl_tvalid_o), 64'd1);
    chk("user_ctrl_type", 64'(ctrl_type_o), 64'h7FFF);
    send_beat(64'h0000_0000_0000_0002, 8'h01, 1'b1, w);
    chk("user_tlast", 64'(ctrl_tlast_o), 64'd1);
    chk("malf_pulse_count", 64'(drop_seen - d0), 64'd1);

    // type boundaries and a malformed data head
    send_beat(64'h8007_0000_0000_0007, 8'hFF, 1'b1, w);
    chk("type7_ctrl_vld", 64'(ctrl_tvalid_o), 64'd1);
    chk("type7_ctrl_type", 64'(ctrl_type_o), 64'd7);
    send_beat(64'h8008_0000_0000_0008, 8'hFF, 1'b1, w);
    chk("type8_drop", 64'(drop_pulse_o), 64'd1);
    chk("type8_any_vld", 64'(data_tvalid_o | ctrl_tvalid_o | close_tvalid_o), 64'd0);
    chk("type8_ctrl_type", 64'(ctrl_type_o), 64'd7);
    send_beat(64'h0000_0000_0000_00F0, 8'h0F, 1'b1, w);
    chk("malf_data_drop", 64'(drop_pulse_o), 64'd1);
    send_beat(64'h8000_0000_0000_0000, 8'hFF, 1'b1, w);
    chk("type0_ctrl_type", 64'(ctrl_type_o), 64'd0);

    // reset during beat 2 of a 4-beat ctrl packet
    send_beat(64'h8003_0000_0000_0003, 8'hFF, 1'b0, w);
    chk("rstmid_ctrl_vld", 64'(ctrl_tvalid_o), 64'd1);
    in_tvalid_i = 1'b1;
    in_tdata_i  = 64'h8005_0000_0000_0004;
    in_tkeep_i  = 8'hFF;
    in_tlast_i  = 1'b0;
    core_rst    = 1'b1;
    @(posedge core_clk); #1;
    core_rst    = 1'b0;
    in_tvalid_i = 1'b0;
    model_reset();
    chk("rstmid_any_vld", 64'(data_tvalid_o | ctrl_tvalid_o | close_tvalid_o), 64'd0);
    chk("rstmid_ctrl_type", 64'(ctrl_type_o), 64'd0);
    send_beat(64'h8005_0000_0000_0042, 8'hFF, 1'b1, w);
    chk("rstmid_head_close", 64'(close_tvalid_o), 64'd1);
    chk("rstmid_head_ctrl", 64'(ctrl_tvalid_o), 64'd0);

    repeat (5) @(posedge core_clk);
    #1;
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("drop_total", 64'(drop_seen), 64'(exp_drops));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
